// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: decoded ID fields and forwarding selects in, registered EX fields out.
`timescale 1ns/1ps
interface id_ex_operand_stage_if #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4
);
  logic               validD;
  logic               flushD;
  logic [DATA_W-1:0]  rs_dataD;
  logic [DATA_W-1:0]  rt_dataD;
  logic [DATA_W-1:0]  immD;
  logic [4:0]         rs_addrD;
  logic [4:0]         rt_addrD;
  logic [4:0]         wb_addrD;
  logic               RegWriteD;
  logic               MemReadD;
  logic               MemWriteD;
  logic               ALUSrcD;
  logic [ALUOP_W-1:0] ALUOpD;
  logic [1:0]         ForwardA;
  logic [1:0]         ForwardB;
  logic [DATA_W-1:0]  ex_fwd_data;
  logic [DATA_W-1:0]  mem_fwd_data;

  logic               validE;
  logic [DATA_W-1:0]  rs_dataE;
  logic [DATA_W-1:0]  rt_dataE;
  logic [DATA_W-1:0]  immE;
  logic [4:0]         rs_addrE;
  logic [4:0]         rt_addrE;
  logic [4:0]         wb_addrE;
  logic               RegWriteE;
  logic               MemReadE;
  logic               MemWriteE;
  logic               ALUSrcE;
  logic [ALUOP_W-1:0] ALUOpE;
  logic               stall_out;

  modport master (
    output validD, flushD, rs_dataD, rt_dataD, immD, rs_addrD, rt_addrD, wb_addrD,
           RegWriteD, MemReadD, MemWriteD, ALUSrcD, ALUOpD, ForwardA, ForwardB,
           ex_fwd_data, mem_fwd_data,
    input  validE, rs_dataE, rt_dataE, immE, rs_addrE, rt_addrE, wb_addrE,
           RegWriteE, MemReadE, MemWriteE, ALUSrcE, ALUOpE, stall_out
  );

  modport slave (
    input  validD, flushD, rs_dataD, rt_dataD, immD, rs_addrD, rt_addrD, wb_addrD,
           RegWriteD, MemReadD, MemWriteD, ALUSrcD, ALUOpD, ForwardA, ForwardB,
           ex_fwd_data, mem_fwd_data,
    output validE, rs_dataE, rt_dataE, immE, rs_addrE, rt_addrE, wb_addrE,
           RegWriteE, MemReadE, MemWriteE, ALUSrcE, ALUOpE, stall_out
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding mux, load-use stall and flush bubbles.
// Optional ID_EX_PERF_COUNT_EN adds bubble_count and stall_count outputs.
`timescale 1ns/1ps
module id_ex_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
`ifdef ID_EX_PERF_COUNT_EN
  output logic [31:0] bubble_count,
  output logic [31:0] stall_count,
`endif
  id_ex_operand_stage_if.slave bus
);

  typedef enum logic [0:0] {RUN, LSTALL} stateT;

  stateT             state;
  stateT             nextState;
  logic              hazard;
  logic              doCapture;
  logic [DATA_W-1:0] rsFwd;
  logic [DATA_W-1:0] rtFwd;

  function automatic logic [DATA_W-1:0] fwdSel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] regData,
    input logic [DATA_W-1:0] exData,
    input logic [DATA_W-1:0] memData
  );
    case (sel)
      2'b10:   fwdSel = exData;
      2'b01:   fwdSel = memData;
      default: fwdSel = regData;
    endcase
  endfunction

  assign rsFwd = fwdSel(bus.ForwardA, bus.rs_dataD, bus.ex_fwd_data, bus.mem_fwd_data);
  assign rtFwd = fwdSel(bus.ForwardB, bus.rt_dataD, bus.ex_fwd_data, bus.mem_fwd_data);

  // Hazard is only evaluated in RUN; during LSTALL the held instruction is captured unconditionally.
  always_comb begin
    hazard = (state == RUN) && bus.validD && bus.validE && bus.MemReadE &&
             (bus.wb_addrE != 5'd0) &&
             ((bus.wb_addrE == bus.rs_addrD) || (bus.wb_addrE == bus.rt_addrD));
    bus.stall_out = hazard && !bus.flushD && !RESET;
    nextState = state;
    doCapture = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.flushD) begin
          doCapture = 1'b0;
        end else if (hazard) begin
          nextState = LSTALL;
        end else begin
          doCapture = bus.validD;
        end
      end
      LSTALL: begin
        nextState = RUN;
        doCapture = bus.validD && !bus.flushD;
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Any edge that does not capture (reset, flush, hazard, empty ID) leaves an all-zero bubble.
  always_ff @(posedge CLOCK) begin
    if (RESET || !doCapture) begin
      bus.validE    <= 1'b0;
      bus.rs_dataE  <= '0;
      bus.rt_dataE  <= '0;
      bus.immE      <= '0;
      bus.rs_addrE  <= '0;
      bus.rt_addrE  <= '0;
      bus.wb_addrE  <= '0;
      bus.RegWriteE <= 1'b0;
      bus.MemReadE  <= 1'b0;
      bus.MemWriteE <= 1'b0;
      bus.ALUSrcE   <= 1'b0;
      bus.ALUOpE    <= '0;
    end else begin
      bus.validE    <= 1'b1;
      bus.rs_dataE  <= rsFwd;
      bus.rt_dataE  <= rtFwd;
      bus.immE      <= bus.immD;
      bus.rs_addrE  <= bus.rs_addrD;
      bus.rt_addrE  <= bus.rt_addrD;
      bus.wb_addrE  <= bus.wb_addrD;
      bus.RegWriteE <= bus.RegWriteD;
      bus.MemReadE  <= bus.MemReadD;
      bus.MemWriteE <= bus.MemWriteD;
      bus.ALUSrcE   <= bus.ALUSrcD;
      bus.ALUOpE    <= bus.ALUOpD;
    end
  end

`ifdef ID_EX_PERF_COUNT_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      bubble_count <= '0;
      stall_count  <= '0;
    end else begin
      if (!doCapture) begin
        bubble_count <= bubble_count + 32'd1;
      end
      if (bus.stall_out) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed vectors push expected EX fields, a monitor pops and compares.
`timescale 1ns/1ps
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        validD;
    logic        flushD;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [4:0]  wbAddr;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        aluSrc;
    logic [3:0]  aluOp;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic [31:0] exFwd;
    logic [31:0] memFwd;
  } dInT;

  typedef struct packed {
    logic        validE;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [4:0]  wbAddr;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        aluSrc;
    logic [3:0]  aluOp;
  } eOutT;

  typedef struct {
    string name;
    eOutT  e;
  } expT;

  logic CLOCK;
  logic RESET;
  int   checks;
  int   errors;
  expT  scoreboard[$];

  id_ex_operand_stage_if #(.DATA_W(32), .ALUOP_W(4)) bus ();

  id_ex_operand_stage #(.DATA_W(32), .ALUOP_W(4)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic dInT mk(input logic [4:0] rsA, input logic [4:0] rtA, input logic [4:0] wbA,
                             input logic mr, input logic [1:0] fa, input logic [1:0] fb);
    dInT d;
    d          = '0;
    d.validD   = 1'b1;
    d.rsData   = 32'h11;
    d.rtData   = 32'h22;
    d.imm      = 32'h1234;
    d.rsAddr   = rsA;
    d.rtAddr   = rtA;
    d.wbAddr   = wbA;
    d.regWrite = 1'b1;
    d.memRead  = mr;
    d.aluSrc   = mr;
    d.aluOp    = 4'h2;
    d.fwdA     = fa;
    d.fwdB     = fb;
    d.exFwd    = 32'hAA;
    d.memFwd   = 32'hBB;
    return d;
  endfunction

  function automatic eOutT capE(input dInT d, input logic [31:0] rsV, input logic [31:0] rtV);
    eOutT e;
    e.validE   = 1'b1;
    e.rsData   = rsV;
    e.rtData   = rtV;
    e.imm      = d.imm;
    e.rsAddr   = d.rsAddr;
    e.rtAddr   = d.rtAddr;
    e.wbAddr   = d.wbAddr;
    e.regWrite = d.regWrite;
    e.memRead  = d.memRead;
    e.memWrite = d.memWrite;
    e.aluSrc   = d.aluSrc;
    e.aluOp    = d.aluOp;
    return e;
  endfunction

  function automatic dInT withFlush(input dInT d);
    dInT r;
    r        = d;
    r.flushD = 1'b1;
    return r;
  endfunction

  task automatic applyStimulus(input string name, input dInT d, input logic rst,
                               input logic expStall, input eOutT expE);
    expT x;
    @(negedge CLOCK);
    RESET            = rst;
    bus.validD       = d.validD;
    bus.flushD       = d.flushD;
    bus.rs_dataD     = d.rsData;
    bus.rt_dataD     = d.rtData;
    bus.immD         = d.imm;
    bus.rs_addrD     = d.rsAddr;
    bus.rt_addrD     = d.rtAddr;
    bus.wb_addrD     = d.wbAddr;
    bus.RegWriteD    = d.regWrite;
    bus.MemReadD     = d.memRead;
    bus.MemWriteD    = d.memWrite;
    bus.ALUSrcD      = d.aluSrc;
    bus.ALUOpD       = d.aluOp;
    bus.ForwardA     = d.fwdA;
    bus.ForwardB     = d.fwdB;
    bus.ex_fwd_data  = d.exFwd;
    bus.mem_fwd_data = d.memFwd;
    #1;
    checks++;
    if (bus.stall_out !== expStall) begin
      errors++;
      $display("FAIL stall[%s]: got %b want %b", name, bus.stall_out, expStall);
    end
    x.name = name;
    x.e    = expE;
    scoreboard.push_back(x);
  endtask

  task automatic checkOutput(input string name, input eOutT got, input eOutT want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL eOut[%s]: got validE=%b rs=%h rt=%h all=%h want validE=%b rs=%h rt=%h all=%h",
               name, got.validE, got.rsData, got.rtData, got,
               want.validE, want.rsData, want.rtData, want);
    end
  endtask

  initial begin
    expT  x;
    eOutT got;
    forever begin
      @(posedge CLOCK);
      #1;
      if (scoreboard.size() > 0) begin
        x   = scoreboard.pop_front();
        got = {bus.validE, bus.rs_dataE, bus.rt_dataE, bus.immE, bus.rs_addrE, bus.rt_addrE,
               bus.wb_addrE, bus.RegWriteE, bus.MemReadE, bus.MemWriteE, bus.ALUSrcE, bus.ALUOpE};
        checkOutput(x.name, got, x.e);
      end
    end
  end

  initial begin
    dInT  idle;
    dInT  a;
    dInT  b;
    dInT  c;
    dInT  ld5;
    dInT  use5;
    dInT  use5h;
    dInT  ld0;
    dInT  use0;
    dInT  ld5b;
    dInT  v;
    dInT  ld8;
    dInT  use8;
    dInT  ld9;
    dInT  use9;
    eOutT zeroE;
    int   waitCycles;

    checks = 0;
    errors = 0;
    zeroE  = '0;
    idle   = '0;
    RESET  = 1'b1;
    bus.validD = 1'b0;
    bus.flushD = 1'b0;

    a     = mk(5'd1, 5'd2, 5'd3, 1'b0, 2'b10, 2'b01);
    b     = mk(5'd1, 5'd2, 5'd3, 1'b0, 2'b11, 2'b00);
    c     = mk(5'd1, 5'd2, 5'd3, 1'b0, 2'b01, 2'b10);
    ld5   = mk(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 2'b00);
    use5  = mk(5'd5, 5'd6, 5'd7, 1'b0, 2'b00, 2'b00);
    use5h = mk(5'd5, 5'd6, 5'd7, 1'b0, 2'b01, 2'b00);
    ld0   = mk(5'd1, 5'd2, 5'd0, 1'b1, 2'b00, 2'b00);
    use0  = mk(5'd0, 5'd0, 5'd4, 1'b0, 2'b00, 2'b11);
    ld5b  = mk(5'd3, 5'd4, 5'd5, 1'b1, 2'b00, 2'b00);
    v     = mk(5'd5, 5'd6, 5'd7, 1'b0, 2'b10, 2'b10);
    ld8   = mk(5'd1, 5'd2, 5'd8, 1'b1, 2'b00, 2'b00);
    use8  = mk(5'd9, 5'd8, 5'd7, 1'b0, 2'b00, 2'b00);
    ld9   = mk(5'd1, 5'd2, 5'd9, 1'b1, 2'b00, 2'b00);
    use9  = mk(5'd9, 5'd3, 5'd7, 1'b0, 2'b00, 2'b00);

    applyStimulus("reset0", idle, 1'b1, 1'b0, zeroE);
    applyStimulus("reset1", idle, 1'b1, 1'b0, zeroE);
    applyStimulus("idle", idle, 1'b0, 1'b0, zeroE);
    applyStimulus("fwdExMem", a, 1'b0, 1'b0, capE(a, 32'hAA, 32'hBB));
    applyStimulus("fwdRegFile", b, 1'b0, 1'b0, capE(b, 32'h11, 32'h22));
    applyStimulus("fwdMemEx", c, 1'b0, 1'b0, capE(c, 32'hBB, 32'hAA));
    applyStimulus("load5", ld5, 1'b0, 1'b0, capE(ld5, 32'h11, 32'h22));
    applyStimulus("use5Stall", use5, 1'b0, 1'b1, zeroE);
    applyStimulus("use5Held", use5h, 1'b0, 1'b0, capE(use5h, 32'hBB, 32'h22));
    applyStimulus("load0", ld0, 1'b0, 1'b0, capE(ld0, 32'h11, 32'h22));
    applyStimulus("use0NoStall", use0, 1'b0, 1'b0, capE(use0, 32'h11, 32'h22));
    applyStimulus("load5b", ld5b, 1'b0, 1'b0, capE(ld5b, 32'h11, 32'h22));
    applyStimulus("hazardFlush", withFlush(use5), 1'b0, 1'b0, zeroE);
    applyStimulus("afterFlush", v, 1'b0, 1'b0, capE(v, 32'hAA, 32'hAA));
    applyStimulus("load8", ld8, 1'b0, 1'b0, capE(ld8, 32'h11, 32'h22));
    applyStimulus("use8ResetRun", use8, 1'b1, 1'b0, zeroE);
    applyStimulus("load8Again", ld8, 1'b0, 1'b0, capE(ld8, 32'h11, 32'h22));
    applyStimulus("use8RtStall", use8, 1'b0, 1'b1, zeroE);
    applyStimulus("resetInStall", use8, 1'b1, 1'b0, zeroE);
    applyStimulus("load9", ld9, 1'b0, 1'b0, capE(ld9, 32'h11, 32'h22));
    applyStimulus("use9Stall", use9, 1'b0, 1'b1, zeroE);
    applyStimulus("flushInStall", withFlush(use9), 1'b0, 1'b0, zeroE);
    applyStimulus("idle2", idle, 1'b0, 1'b0, zeroE);
    applyStimulus("use9Clean", use9, 1'b0, 1'b0, capE(use9, 32'h11, 32'h22));

    waitCycles = 0;
    while (scoreboard.size() > 0 && waitCycles < 10) begin
      @(posedge CLOCK);
      waitCycles++;
    end
    #2;
    if (scoreboard.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", scoreboard.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register of the 5-stage MIPS pipeline. It sits directly downstream of the forwarding unit and consumes ForwardA/ForwardB. On each capture edge it selects each source operand from the register file, the EX-stage result or the MEM-stage result, then registers the operands with decoded control into the EX stage. It also detects load-use hazards, requests a one-cycle front-end stall and inserts a bubble; a branch flush input also inserts bubbles.

Parameters:
DATA_W, 32, operand and immediate width
ALUOP_W, 4, ALU operation code width

Ports:
CLOCK  in  1  pipeline clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
validD  in  1  ID stage holds a real instruction
flushD  in  1  branch/jump flush; discard ID instruction
rs_dataD  in  DATA_W  register-file read data, rs
rt_dataD  in  DATA_W  register-file read data, rt
immD  in  DATA_W  sign/zero-extended immediate
rs_addrD  in  5  rs index
rt_addrD  in  5  rt index
wb_addrD  in  5  destination index
RegWriteD, MemReadD, MemWriteD, ALUSrcD  in  1 each  decoded control
ALUOpD  in  ALUOP_W  ALU operation
ForwardA  in  2  rs source select from forwarding unit
ForwardB  in  2  rt source select from forwarding unit
ex_fwd_data  in  DATA_W  result currently produced in EX
mem_fwd_data  in  DATA_W  result currently in MEM
validE  out  1  EX stage holds a real instruction
rs_dataE, rt_dataE, immE  out  DATA_W  registered operands
rs_addrE, rt_addrE, wb_addrE  out  5  registered indices
RegWriteE, MemReadE, MemWriteE, ALUSrcE  out  1 each  registered control
ALUOpE  out  ALUOP_W  registered ALU op
stall_out  out  1  hold PC and IF/ID this cycle (combinational)

Behaviour:
- Reset (RESET=1 at edge): every E output is 0, FSM goes to RUN. While RESET is high, stall_out is 0.
- Forward mux, per operand: 2'b10 selects ex_fwd_data; 2'b01 selects mem_fwd_data; 2'b00 and 2'b11 select the register-file data. ForwardA drives rs and ForwardB drives rt. immD is never forwarded.
- Load-use hazard (combinational):
  - Condition: FSM in RUN, validD=1, validE=1, MemReadE=1, wb_addrE!=0, and wb_addrE equals rs_addrD or rt_addrD.
  - stall_out equals this condition unless flushD=1, which forces stall_out to 0.
- FSM states:
  - RUN: priority at each edge is flush > hazard > capture.
    - flushD=1: insert bubble, stay RUN.
    - Hazard: insert bubble, go to LSTALL.
    - validD=0: insert bubble, stay RUN.
    - Otherwise: capture forwarded operands and all D fields, set validE=1, stay RUN.
  - LSTALL: lasts exactly one cycle and always returns to RUN.
    - Upstream holds the same ID instruction. No hazard check is made, so stall_out=0.
    - flushD=1: insert bubble.
    - Otherwise: capture normally. The loaded value now arrives via ForwardX=01.
- Bubble: validE=0; RegWriteE, MemReadE, MemWriteE, ALUSrcE, ALUOpE, wb_addrE, rs_addrE, rt_addrE, rs_dataE, rt_dataE and immE are all cleared to 0.
- Latency: one cycle from D inputs to E outputs. A load-use pair costs exactly one bubble.
- RESET mid-stall: FSM returns to RUN, stall_out drops in the same cycle, and no pending capture is retained.
- Register $0: a hazard on index 0 is never flagged. Forwarded data is taken as given.

Optional Feature:
Macro: ID_EX_PERF_COUNT_EN.
- Defined: adds outputs bubble_count (32-bit) and stall_count (32-bit).
  - bubble_count increments at every edge that inserts a bubble while RESET=0.
  - stall_count increments at every edge where stall_out=1.
  - Both clear on RESET and wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- RESET held 2 cycles, then released with validD=0: all E outputs 0, stall_out=0, validE stays 0.
- validD=1, rs_dataD=0x11, ForwardA=10, ex_fwd_data=0xAA, ForwardB=01, mem_fwd_data=0xBB, rt_dataD=0x22: next edge gives rs_dataE=0xAA and rt_dataE=0xBB. Repeat with ForwardA=11: rs_dataE=0x11.
- Load to $5 captured into EX (MemReadE=1, wb_addrE=5), next ID uses rs_addrD=5:
  - stall_out=1 that cycle; next edge gives a bubble (validE=0, RegWriteE=0).
  - Following edge captures the held instruction with stall_out=0.
- Same load-use case but wb_addrE=0: stall_out=0 and the instruction is captured immediately.
- Hazard and flushD=1 in the same cycle: stall_out=0, bubble inserted, FSM stays RUN, and the next valid instruction is captured on the following edge.
- RESET asserted in LSTALL: next edge all E outputs 0, FSM in RUN. With ID_EX_PERF_COUNT_EN defined: after one load-use stall plus one flush, stall_count=1 and bubble_count=2.
